// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_unit
// Brief   : Instruction fetch stage. A byte-address PC drives a word-indexed
//           instruction cache (1 KiB alias window). Fetched {pc, instr}
//           pairs are held in a 2-entry in-order buffer that feeds decode.
//           Redirects flush the buffer and retarget the PC.
// Revision: 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  icache_a,
    input  logic [31:0] icache_q,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam logic [31:0] c_RESET_PC_ALIGNED = RESET_PC & ~32'h3;
    localparam logic [1:0]  c_DEPTH            = 2'd2;

    // Fetch PC and buffer occupancy
    logic [31:0] r_fetch_pc;
    logic [1:0]  r_count;

    // Entry 0 is always the head; entry 1 is the tail when two are held
    logic [31:0] r_pc0;
    logic [31:0] r_instr0;
    logic [31:0] r_pc1;
    logic [31:0] r_instr1;

    logic        w_pop;
    logic        w_push;
    logic [1:0]  w_wr_slot;
    logic [31:0] w_redirect_aligned;

    assign icache_a  = r_fetch_pc[9:2];
    assign out_valid = (r_count != 2'd0);
    assign out_pc    = r_pc0;
    assign out_instr = r_instr0;

    assign w_pop              = out_valid & out_ready;
    assign w_push             = fetch_en & ~redirect_valid & ((r_count != c_DEPTH) | w_pop);
    // Slot the new entry lands in, after any same-cycle dequeue has shifted the head
    assign w_wr_slot          = r_count - {1'b0, w_pop};
    assign w_redirect_aligned = redirect_pc & ~32'h3;

    // PC and occupancy: reset beats redirect, redirect beats push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= c_RESET_PC_ALIGNED;
            r_count    <= 2'd0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_aligned;
            r_count    <= 2'd0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer payload: shift on pop, then append the fetched word at the tail
    always_ff @(posedge clk) begin
        if (!reset && !redirect_valid) begin
            if (w_pop) begin
                r_pc0    <= r_pc1;
                r_instr0 <= r_instr1;
            end
            if (w_push) begin
                if (w_wr_slot == 2'd0) begin
                    r_pc0    <= r_fetch_pc;
                    r_instr0 <= icache_q;
                end else begin
                    r_pc1    <= r_fetch_pc;
                    r_instr1 <= icache_q;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifetch_unit
// Brief   : Directed self-checking bench for ifetch_unit. Two instances:
//           one with RESET_PC = 0, one with RESET_PC = FFFF_FFF8 for wrap.
//           The instruction cache returns 32'h1000_0000 + word index.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    logic        clk;
    logic        reset;
    logic [7:0]  icache_a;
    logic [31:0] icache_q;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    logic        w_reset;
    logic [7:0]  w_icache_a;
    logic [31:0] w_icache_q;
    logic        w_out_valid;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;
    logic        w_fetch_en;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_out_ready;

    int n_asserts = 0;
    int n_fail    = 0;

    // Preloaded cache model: word[i] = 32'h1000_0000 + i
    assign icache_q   = 32'h1000_0000 + {24'd0, icache_a};
    assign w_icache_q = 32'h1000_0000 + {24'd0, w_icache_a};

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_a       (icache_a),
        .icache_q       (icache_q),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .reset          (w_reset),
        .icache_a       (w_icache_a),
        .icache_q       (w_icache_q),
        .fetch_en       (w_fetch_en),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .out_valid      (w_out_valid),
        .out_ready      (w_out_ready),
        .out_instr      (w_out_instr),
        .out_pc         (w_out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset            = 1'b1;
        fetch_en         = 1'b1;
        out_ready        = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        w_reset          = 1'b1;
        w_fetch_en       = 1'b1;
        w_out_ready      = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = 32'h0;

        // ---- reset state ----
        step();
        step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_icache_a", {24'd0, icache_a}, 32'h00);
        chk("wrap_rst_icache_a", {24'd0, w_icache_a}, 32'hFE);
        chk("wrap_rst_valid", {31'd0, w_out_valid}, 32'd0);

        // ---- streaming ----
        reset = 1'b0;
        step();
        for (int k = 0; k < 6; k++) begin
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_pc", out_pc, 32'(4 * k));
            chk("stream_instr", out_instr, 32'h1000_0000 + 32'(k));
            step();
        end

        // ---- backpressure from reset release ----
        reset = 1'b1;
        step();
        chk("bp_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_rst_icache_a", {24'd0, icache_a}, 32'h00);
        reset     = 1'b0;
        out_ready = 1'b0;
        step();
        chk("bp1_pc", out_pc, 32'h0);
        chk("bp1_icache_a", {24'd0, icache_a}, 32'h01);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_pc", out_pc, 32'h0);
            chk("bp_hold_instr", out_instr, 32'h1000_0000);
            chk("bp_hold_icache_a", {24'd0, icache_a}, 32'h02);
        end
        out_ready = 1'b1;
        step();
        chk("bp_pop1_pc", out_pc, 32'h4);
        chk("bp_pop1_instr", out_instr, 32'h1000_0001);
        chk("bp_pop1_icache_a", {24'd0, icache_a}, 32'h03);
        step();
        chk("bp_pop2_pc", out_pc, 32'h8);
        chk("bp_pop2_instr", out_instr, 32'h1000_0002);

        // ---- redirect while full (entries 8, 12 buffered) ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        step();
        redirect_valid = 1'b0;
        chk("redir_bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_icache_a", {24'd0, icache_a}, 32'h10);
        step();
        chk("redir_valid", {31'd0, out_valid}, 32'd1);
        chk("redir_pc", out_pc, 32'h40);
        chk("redir_instr", out_instr, 32'h1000_0010);
        step();
        chk("redir_next_pc", out_pc, 32'h44);

        // ---- back-to-back redirects ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        chk("b2b_1_valid", {31'd0, out_valid}, 32'd0);
        redirect_pc = 32'h0000_0202;
        step();
        chk("b2b_2_valid", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b0;
        step();
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_pc", out_pc, 32'h200);
        chk("b2b_instr", out_instr, 32'h1000_0080);

        // ---- fetch_en toggling: fill to 2, then drain with fetch disabled ----
        out_ready = 1'b0;
        step();
        chk("fe_fill_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        fetch_en  = 1'b0;
        step();
        chk("fe_drain1_pc", out_pc, 32'h204);
        chk("fe_drain1_icache_a", {24'd0, icache_a}, 32'h82);
        step();
        chk("fe_drain2_valid", {31'd0, out_valid}, 32'd0);
        chk("fe_drain2_icache_a", {24'd0, icache_a}, 32'h82);
        step();
        chk("fe_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("fe_idle_icache_a", {24'd0, icache_a}, 32'h82);
        fetch_en = 1'b1;
        step();
        chk("fe_resume_valid", {31'd0, out_valid}, 32'd1);
        chk("fe_resume_pc", out_pc, 32'h208);
        chk("fe_resume_instr", out_instr, 32'h1000_0082);

        // ---- reset mid-stream with full buffer and a pending redirect ----
        out_ready = 1'b0;
        step();
        chk("mid_full_pc", out_pc, 32'h208);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        out_ready      = 1'b1;
        step();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_icache_a", {24'd0, icache_a}, 32'h00);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        step();
        chk("mid_resume_valid", {31'd0, out_valid}, 32'd1);
        chk("mid_resume_pc", out_pc, 32'h0);
        chk("mid_resume_instr", out_instr, 32'h1000_0000);

        // ---- PC wrap on the second instance ----
        w_reset = 1'b0;
        step();
        chk("wrap1_pc", w_out_pc, 32'hFFFF_FFF8);
        chk("wrap1_instr", w_out_instr, 32'h1000_00FE);
        chk("wrap1_icache_a", {24'd0, w_icache_a}, 32'hFF);
        step();
        chk("wrap2_pc", w_out_pc, 32'hFFFF_FFFC);
        chk("wrap2_instr", w_out_instr, 32'h1000_00FF);
        chk("wrap2_icache_a", {24'd0, w_icache_a}, 32'h00);
        step();
        chk("wrap3_pc", w_out_pc, 32'h0000_0000);
        chk("wrap3_instr", w_out_instr, 32'h1000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address of the first fetch after reset.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port icache_a, output, 8 bits: word address to the instruction cache.
REQ-005 The module SHALL have port icache_q, input, 32 bits: instruction word returned combinationally for icache_a in the same cycle.
REQ-006 The module SHALL have port fetch_en, input, 1 bit: when low, no new fetch is enqueued and the PC holds.
REQ-007 The module SHALL have port redirect_valid, input, 1 bit: a branch/jump redirect request.
REQ-008 The module SHALL have port redirect_pc, input, 32 bits: the redirect target byte address.
REQ-009 The module SHALL have port out_valid, output, 1 bit: the fetch buffer head is valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: decode accepts the head.
REQ-011 The module SHALL have port out_instr, output, 32 bits: head instruction word.
REQ-012 The module SHALL have port out_pc, output, 32 bits: head instruction byte address.

Function
REQ-013 The block SHALL hold a 32-bit register fetch_pc and drive icache_a = fetch_pc[9:2] combinationally; bits [31:10] SHALL be ignored for addressing, so addresses alias every 1 KiB.
REQ-014 The block SHALL contain a 2-entry FIFO of {pc, instr} pairs with a count of 0..2; out_valid = (count != 0); out_instr/out_pc SHALL show the head entry.
REQ-015 pop = out_valid & out_ready; when out_valid is low, out_ready SHALL be ignored.
REQ-016 push = fetch_en & ~redirect_valid & (count < 2 | pop).
  - A push SHALL enqueue {fetch_pc, icache_q} at the clock edge.
  - A push SHALL advance fetch_pc by 4, with modulo-2^32 wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 Count update: push only +1; pop only -1; push and pop together leave count unchanged, with the head dequeued and the new entry appended in order.
REQ-018 Full boundary:
  - With count = 2 and no pop, no push SHALL occur, fetch_pc SHALL hold, and the FIFO contents SHALL be unchanged.
  - With count = 2 and a pop, the push SHALL proceed in the same cycle.
REQ-019 Empty boundary: with count = 0, a push SHALL make out_valid high at the next edge. There is no same-cycle bypass: fetch-to-out latency is exactly 1 cycle.
REQ-020 Redirect: when redirect_valid = 1 at an edge, the block SHALL:
  - set fetch_pc <= {redirect_pc[31:2], 2'b00} (low bits forced to zero);
  - set count <= 0;
  - suppress the push;
  - discard any concurrent pop.
  Redirect SHALL have priority over fetch_en, pop and full.
REQ-021 After a redirect edge, out_valid SHALL be low for exactly one cycle, provided fetch_en = 1. The target instruction SHALL then appear with out_pc = aligned target.
REQ-022 Back-to-back redirects SHALL each override the previous target; only the last target SHALL be fetched.
REQ-023 While fetch_en = 0, the buffered entries SHALL remain poppable and the count SHALL only decrease.
REQ-024 Program order SHALL be preserved: out_pc of consecutive pops SHALL differ by exactly 4 unless a redirect intervened.
REQ-025 out_instr and out_pc SHALL be stable while out_valid = 1 and out_ready = 0.

Reset
REQ-026 When reset = 1 at a rising clk edge, the block SHALL set:
  - fetch_pc <= RESET_PC & ~3;
  - count <= 0.
  Reset SHALL override redirect, push and pop.
REQ-027 During and in the cycle after reset, out_valid SHALL be 0, and icache_a SHALL equal RESET_PC[9:2].
REQ-028 The out_instr/out_pc values while out_valid = 0 are don't-care, and benches SHALL NOT check them.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries with no partial pop.

Verification
REQ-030 Streaming: icache preloaded with word[i] = 32'h1000_0000 + i, RESET_PC = 0, fetch_en = 1, out_ready = 1 from reset release.
  - Required: out_valid from cycle 1 onward.
  - Required: consecutive out_pc = 0, 4, 8, ... with matching out_instr = 32'h1000_0000, 32'h1000_0001, ...
REQ-031 Backpressure: out_ready = 0 for 5 cycles from reset release.
  - Required: count saturates at 2 and icache_a holds 8'h02.
  - Required: out_pc = 0 stays stable.
  - After out_ready = 1, required pops are out_pc 0, 4, 8 with no gap or duplicate.
REQ-032 Redirect: redirect_pc = 32'h0000_0043 while count = 2 and out_ready = 1.
  - Required: the next cycle has out_valid = 0.
  - Required: the following head has out_pc = 32'h40 and out_instr = word[16].
  - Required: the pre-redirect entries never appear.
REQ-033 Wrap: RESET_PC = 32'hFFFF_FFF8 with streaming.
  - Required: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - Required: icache_a sequence 8'hFE, 8'hFF, 8'h00.
REQ-034 Reset mid-stream: reset asserted for 1 cycle with count = 2 and redirect_valid = 1.
  - Required: out_valid = 0 next cycle.
  - Required: fetching resumes at RESET_PC, not at redirect_pc.
REQ-035 fetch_en toggling: fetch_en = 0 for 3 cycles with out_ready = 1.
  - Required: the buffer drains to out_valid = 0 and fetch_pc holds.
  - Required: on re-enable, out_pc continues at the next sequential address.
